switch_input_ctrl: RTL and testbench
====================================

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd500000, stable-sample count required before accepting a switch change (legal range 2..2^20-1).
REQ-002 SHALL have parameter BASE_ADDR, default 32'hFFFF_F070, 16-byte-aligned base of the register window.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sw, input, 24, raw asynchronous board switches.
REQ-006 SHALL have port addr, input, 32, bus byte address.
REQ-007 SHALL have port rd_en, input, 1, read strobe, one cycle per access.
REQ-008 SHALL have port wr_en, input, 1, write strobe, one cycle per access.
REQ-009 SHALL have port wdata, input, 32, write data.
REQ-010 SHALL have port data, output, 32, registered read data.
REQ-011 SHALL have port irq, output, 1, level interrupt, switch-change pending.

Function
REQ-012 SHALL pass sw through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 SHALL run a debounce FSM with states STABLE and SETTLE, a 24-bit candidate register cand, a 20-bit counter cnt and a 24-bit stable register.
REQ-014 In STABLE, s2 != stable SHALL load cand <= s2, clear cnt and enter SETTLE; otherwise hold.
REQ-015 In SETTLE, s2 != cand SHALL load cand <= s2 and clear cnt (restart); s2 == cand and cnt == DEBOUNCE_CYCLES-1 SHALL load stable <= cand and return to STABLE; otherwise cnt increments.
REQ-016 Latency from a clean sw change to updated stable SHALL be exactly DEBOUNCE_CYCLES+3 rising edges.
REQ-017 On every stable update SHALL OR (old stable XOR cand) into a 24-bit sticky edge register; a settle that returns to the old value sets no bits.
REQ-018 Register window hit SHALL be addr[31:4] == BASE_ADDR[31:4]; offset = addr[3:2].
REQ-019 Offset 0 (DATA, RO) SHALL read {8'h00, stable}.
REQ-020 Offset 1 (STATUS, RO) SHALL read {30'b0, state==SETTLE, |edge}.
REQ-021 Offset 2 (EDGE, RO, clear-on-read) SHALL read {8'h00, edge}; that read clears edge.
REQ-022 Offset 3 (CTRL, RW) SHALL hold irq_en in bit 0; other bits read 0, writes to them ignored.
REQ-023 data SHALL update one cycle after a rd_en cycle with the selected value, 32'h0 on a window miss, and otherwise hold its last value.
REQ-024 wr_en to offsets 0-2 or a window miss SHALL have no effect.
REQ-025 Read of EDGE in the same cycle as a stable update SHALL return the pre-update edge value and leave edge equal to only the newly changed bits.
REQ-026 rd_en and wr_en asserted together SHALL perform both; read returns the pre-write CTRL value.
REQ-027 irq SHALL be registered, equal to irq_en & (|edge), one cycle after either operand changes.

Reset
REQ-028 rst high SHALL immediately force s1, s2, cand, stable, edge, cnt, irq_en, data and irq to 0 and state to STABLE, regardless of clk.
REQ-029 rst asserted mid-SETTLE SHALL discard the pending change; after release, a held nonzero sw SHALL be re-debounced from the start (full DEBOUNCE_CYCLES+3 latency).

Verification (DEBOUNCE_CYCLES=4, BASE_ADDR=32'hFFFF_F070)
REQ-030 Reset, sw=24'h00_00A5 held -> DATA read returns 32'h0000_00A5 after 7 edges; STATUS returns 32'h1; EDGE returns 32'h0000_00A5, then 32'h0 on re-read.
REQ-031 sw toggles 24'h1 -> 0 -> 1 with 2-cycle gaps, then holds 24'h1 -> stable updates only 7 edges after final toggle; no intermediate values in DATA.
REQ-032 Write CTRL=32'h1, then change sw bit 23 -> irq rises one cycle after edge set; EDGE read returns 32'h0080_0000; irq falls one cycle after clear.
REQ-033 EDGE read coincident with stable update of bit 0 while edge=24'h2 -> data=32'h2, edge afterwards 24'h1.
REQ-034 rd_en with addr=32'hFFFF_F080 -> data=32'h0; wr_en to DATA offset -> no state change.
REQ-035 rst pulsed at cnt=2 in SETTLE, sw held 24'h3 -> all outputs 0 immediately; DATA becomes 24'h3 exactly 7 edges after release.

Source files
------------

// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl
//   Samples 24 board switches through a two-flop synchronizer and debounces
//   them. A switch change is accepted only after it has been sampled
//   unchanged for DEBOUNCE_CYCLES clocks. Bits that change at acceptance are
//   latched in a sticky edge register. A four-word register window exposes
//   the state to a simple strobe bus.
//
//   Register map (byte offsets from BASE_ADDR):
//     0x0 DATA   RO  {8'h00, stable}
//     0x4 STATUS RO  {30'b0, settling, edge pending}
//     0x8 EDGE   RO  {8'h00, edge}; a read clears edge
//     0xC CTRL   RW  bit 0 = irq_en
//
//   Ports:
//     clk    sole clock, rising edge
//     rst    asynchronous active-high reset
//     sw     raw asynchronous switch inputs (24)
//     addr   bus byte address (32)
//     rd_en  read strobe, one cycle per access
//     wr_en  write strobe, one cycle per access
//     wdata  write data (32)
//     data   registered read data (32); holds between reads
//     irq    registered level interrupt = irq_en & (|edge)
module switch_input_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_F070
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] sw,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] data,
  output logic        irq
);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] s1_q, s1_d;
  logic [23:0] s2_q, s2_d;
  logic [23:0] cand_q, cand_d;
  logic [23:0] stable_q, stable_d;
  logic [23:0] edge_q, edge_d;
  logic [19:0] cnt_q, cnt_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
  logic [31:0] data_q, data_d;

  logic        commit;
  logic        hit;
  logic [1:0]  offset;
  logic [31:0] rd_val;
  logic        rd_edge;
  logic        wr_ctrl;

  // Byte-lane bits of the address and the upper write-data bits carry no
  // meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:1]};

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STABLE;
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      edge_q   <= '0;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      data_q   <= data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE: begin
        if (s2_q != stable_q) state_d = SETTLE;
      end
      SETTLE: begin
        if ((s2_q == cand_q) && (cnt_q == DEBOUNCE_CYCLES - 20'd1)) state_d = STABLE;
      end
      default: state_d = STABLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Debounce datapath (state-dependent outputs of the FSM)
  // ---------------------------------------------------------------------
  always_comb begin
    s1_d   = sw;
    s2_d   = s1_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    case (state_q)
      STABLE: begin
        if (s2_q != stable_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end
      end
      SETTLE: begin
        if (s2_q != cand_q) begin
          // Input moved again: restart the settle window on the new value.
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        cand_d = cand_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Register window
  // ---------------------------------------------------------------------
  always_comb begin
    hit     = (addr[31:4] == BASE_ADDR[31:4]);
    offset  = addr[3:2];
    rd_edge = rd_en && hit && (offset == 2'd2);
    wr_ctrl = wr_en && hit && (offset == 2'd3);

    case (offset)
      2'd0:    rd_val = {8'h00, stable_q};
      2'd1:    rd_val = {30'b0, (state_q == SETTLE), |edge_q};
      2'd2:    rd_val = {8'h00, edge_q};
      default: rd_val = {31'b0, irq_en_q};
    endcase

    data_d = data_q;
    if (rd_en) data_d = hit ? rd_val : '0;

    // Clear-on-read happens first, so a coincident acceptance leaves only
    // the freshly changed bits; the read itself returns the old edge_q.
    edge_d   = rd_edge ? '0 : edge_q;
    stable_d = stable_q;
    if (commit) begin
      edge_d   = edge_d | (stable_q ^ cand_q);
      stable_d = cand_q;
    end

    irq_en_d = wr_ctrl ? wdata[0] : irq_en_q;
    irq_d    = irq_en_q & (|edge_q);
  end

  assign data = data_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
module tb_switch_input_ctrl;

  localparam logic [19:0] DEB    = 20'd4;
  localparam logic [31:0] BASE   = 32'hFFFF_F070;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_EDGE = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [23:0] sw    = '0;
  logic [31:0] addr  = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] data;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .addr(addr),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .wdata(wdata),
    .data(data),
    .irq(irq)
  );

  // -------------------------------------------------------------------
  // Reference model: a change seen on the synchronized input is accepted
  // DEB clocks after the last time that input moved; the pipeline delay
  // is modelled as a two-entry history of sw.
  // -------------------------------------------------------------------
  logic [23:0] m_hist1 = '0, m_hist2 = '0;
  logic [23:0] m_stable = '0, m_cand = '0, m_edge = '0;
  logic        m_pending = 1'b0, m_irq_en = 1'b0, m_irq = 1'b0;
  logic [31:0] m_data = '0;
  int          m_cyc = 0, m_deadline = 0;
  logic [31:0] m_rv;
  logic        m_hit, m_accept;
  logic [23:0] m_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist1 = '0; m_hist2 = '0; m_stable = '0; m_cand = '0; m_edge = '0;
      m_pending = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_data = '0;
    end else begin
      m_hit = (addr[31:4] == BASE[31:4]);
      case (addr[3:2])
        2'd0:    m_rv = {8'h00, m_stable};
        2'd1:    m_rv = {30'b0, m_pending, (m_edge != 24'h0)};
        2'd2:    m_rv = {8'h00, m_edge};
        default: m_rv = {31'b0, m_irq_en};
      endcase
      if (rd_en) m_data = m_hit ? m_rv : 32'h0;
      m_irq = m_irq_en && (m_edge != 24'h0);

      m_seen   = m_hist2;
      m_accept = 1'b0;
      if (m_pending) begin
        if (m_seen != m_cand) begin
          m_cand = m_seen;
          m_deadline = m_cyc + int'(DEB);
        end else if (m_cyc == m_deadline) begin
          m_accept = 1'b1;
        end
      end else if (m_seen != m_stable) begin
        m_pending = 1'b1;
        m_cand = m_seen;
        m_deadline = m_cyc + int'(DEB);
      end

      if (rd_en && m_hit && addr[3:2] == 2'd2) m_edge = '0;
      if (m_accept) begin
        m_edge    = m_edge | (m_stable ^ m_cand);
        m_stable  = m_cand;
        m_pending = 1'b0;
      end
      if (wr_en && m_hit && addr[3:2] == 2'd3) m_irq_en = wdata[0];

      m_hist2 = m_hist1;
      m_hist1 = sw;
      m_cyc++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    n_checks++;
    if (data !== m_data) begin
      n_errors++;
      $display("FAIL data_vs_model t=%0t: got %h expected %h", $time, data, m_data);
    end
    n_checks++;
    if (irq !== m_irq) begin
      n_errors++;
      $display("FAIL irq_vs_model t=%0t: got %b expected %b", $time, irq, m_irq);
    end
  end

  // -------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(nm, data, exp);
    chk({nm, "_model"}, m_data, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int hold;

  initial begin
    tick();
    chk("reset_data", data, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    do_reset();

    // Basic acceptance latency and register contents.
    sw = 24'h00_00A5;
    repeat (6) tick();
    rd_chk(A_DATA, 32'h0, "data_at_edge7_preupdate");
    rd_chk(A_DATA, 32'h0000_00A5, "data_after_debounce");
    rd_chk(A_STAT, 32'h1, "status_edge_pending");
    rd_chk(A_EDGE, 32'h0000_00A5, "edge_first_read");
    rd_chk(A_EDGE, 32'h0, "edge_cleared");

    // Bouncing input: only the final value is accepted.
    sw = 24'h0;
    do_reset();
    repeat (10) tick();
    sw = 24'h1; tick(); tick();
    sw = 24'h0; tick(); tick();
    sw = 24'h1;
    for (int unsigned i = 0; i < 7; i++) rd_chk(A_DATA, 32'h0, "bounce_no_early_update");
    rd_chk(A_DATA, 32'h1, "bounce_final_value");
    rd_chk(A_EDGE, 32'h1, "bounce_edge");

    // Interrupt path.
    wr(A_CTRL, 32'h1);
    rd_chk(A_CTRL, 32'h1, "ctrl_readback");
    sw = 24'h80_0001;
    repeat (7) tick();
    chk("irq_not_yet", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'b0, irq}, 32'h1);
    rd_chk(A_EDGE, 32'h0080_0000, "edge_bit23");
    chk("irq_still_high", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_fall", {31'b0, irq}, 32'h0);

    // Simultaneous read and write of CTRL returns the old value.
    addr = A_CTRL; wdata = 32'h0; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rdwr_old_ctrl", data, 32'h1);
    rd_chk(A_CTRL, 32'h0, "ctrl_after_write");

    // EDGE read coincident with acceptance.
    sw = 24'h0;
    do_reset();
    sw = 24'h2;
    repeat (7) tick();
    sw = 24'h3;
    repeat (6) tick();
    rd_chk(A_EDGE, 32'h2, "edge_read_coincident");
    rd_chk(A_EDGE, 32'h1, "edge_only_new_bits");

    // Window misses and writes to read-only registers.
    rd_chk(A_DATA, 32'h3, "data_before_miss");
    rd_chk(32'hFFFF_F080, 32'h0, "miss_above");
    rd_chk(A_DATA, 32'h3, "data_again");
    rd_chk(32'hFFFF_F06C, 32'h0, "miss_below");
    wr(A_DATA, 32'hFFFF_FFFF);
    wr(A_EDGE, 32'hFFFF_FFFF);
    wr(32'hFFFF_F08C, 32'h1);
    rd_chk(A_DATA, 32'h3, "data_unchanged_by_write");
    rd_chk(A_CTRL, 32'h0, "ctrl_unchanged_by_miss");
    rd_chk(A_STAT, 32'h0, "status_idle");

    // Reset in the middle of a settle window.
    wr(A_CTRL, 32'h1);
    sw = 24'h0;
    repeat (7) tick();
    tick();
    rd_chk(A_STAT, 32'h1, "status_before_rst");
    chk("irq_before_rst", {31'b0, irq}, 32'h1);
    sw = 24'h3;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_async_data", data, 32'h0);
    chk("rst_async_irq", {31'b0, irq}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    rd_chk(A_DATA, 32'h0, "after_rst_not_yet");
    rd_chk(A_DATA, 32'h3, "after_rst_redebounced");

    // Randomized traffic checked against the model every cycle.
    hold = 0;
    for (int unsigned i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        sw = sw ^ (24'h1 << $urandom_range(0, 23));
        if ($urandom_range(0, 3) == 0) sw = sw ^ (24'h1 << $urandom_range(0, 23));
        hold = int'($urandom_range(1, 10));
      end
      hold--;
      rd_en = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2, 3: addr = {BASE[31:4], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        4:          addr = BASE + 32'd16 + 32'($urandom_range(0, 15));
        default:    addr = $urandom;
      endcase
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
